layer_mem_responder: RTL and testbench

LAYER_MEM_RESPONDER -- requirements
Module: layer_mem_responder

---
 rtl/layer_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_layer_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_responder.sv
// Five-bank layer memory responder: per-bank write/read with range checks,
// saturating write counters, registered full flags and sticky error flags.
module layer_mem_responder #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned L0_DEPTH   = 4096,
    parameter int unsigned L1_DEPTH   = 1024,
    parameter int unsigned L2_DEPTH   = 2048
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cwr,
    input  logic [11:0]           caddr_wr,
    input  logic [DATA_WIDTH-1:0] cdata_wr,
    input  logic                  crd,
    input  logic [11:0]           caddr_rd,
    input  logic [2:0]            csel,
    input  logic                  clr_status,
    output logic [DATA_WIDTH-1:0] cdata_rd,
    output logic                  rd_valid,
    output logic [4:0]            layer_full,
    output logic                  err_sel,
    output logic                  err_addr
);

    localparam int unsigned NUM_BANKS = 5;
    localparam int unsigned L0_AW     = (L0_DEPTH > 1) ? $clog2(L0_DEPTH) : 1;
    localparam int unsigned L1_AW     = (L1_DEPTH > 1) ? $clog2(L1_DEPTH) : 1;
    localparam int unsigned L2_AW     = (L2_DEPTH > 1) ? $clog2(L2_DEPTH) : 1;
    localparam int unsigned MAX_01    = (L0_DEPTH > L1_DEPTH) ? L0_DEPTH : L1_DEPTH;
    localparam int unsigned MAX_DEPTH = (MAX_01 > L2_DEPTH) ? MAX_01 : L2_DEPTH;
    localparam int unsigned CNT_W     = $clog2(MAX_DEPTH + 1);

    localparam logic [2:0] BANK_L0K0 = 3'd0;
    localparam logic [2:0] BANK_L0K1 = 3'd1;
    localparam logic [2:0] BANK_L1K0 = 3'd2;
    localparam logic [2:0] BANK_L1K1 = 3'd3;
    localparam logic [2:0] BANK_L2   = 3'd4;

    function automatic int unsigned bank_depth(input logic [2:0] bank);
        case (bank)
            BANK_L0K0, BANK_L0K1: bank_depth = L0_DEPTH;
            BANK_L1K0, BANK_L1K1: bank_depth = L1_DEPTH;
            default:              bank_depth = L2_DEPTH;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] r_mem_l0k0 [L0_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_l0k1 [L0_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_l1k0 [L1_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_l1k1 [L1_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_l2   [L2_DEPTH];

    logic [DATA_WIDTH-1:0] r_cdata_rd;
    logic                  r_rd_valid;
    logic [4:0]            r_layer_full;
    logic                  r_err_sel;
    logic                  r_err_addr;
    logic [CNT_W-1:0]      r_cnt [NUM_BANKS];

    logic                  w_sel_valid;
    logic [2:0]            w_bank;
    int unsigned           w_depth;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_sel_err;
    logic                  w_addr_err;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [CNT_W-1:0]      w_cnt_nxt [NUM_BANKS];
    logic [4:0]            w_full_nxt;

    // Bank decode and per-port acceptance; requests during reset are ignored.
    always_comb begin
        w_sel_valid = 1'b1;
        w_bank      = BANK_L0K0;
        case (csel)
            3'b001:  w_bank = BANK_L0K0;
            3'b010:  w_bank = BANK_L0K1;
            3'b011:  w_bank = BANK_L1K0;
            3'b100:  w_bank = BANK_L1K1;
            3'b101:  w_bank = BANK_L2;
            default: w_sel_valid = 1'b0;
        endcase
        w_depth       = bank_depth(w_bank);
        w_wr_in_range = (32'(caddr_wr) < w_depth);
        w_rd_in_range = (32'(caddr_rd) < w_depth);
        w_wr_en       = reset_n & cwr & w_sel_valid & w_wr_in_range;
        w_rd_en       = reset_n & crd & w_sel_valid & w_rd_in_range;
        w_sel_err     = reset_n & (cwr | crd) & ~w_sel_valid;
        w_addr_err    = reset_n & w_sel_valid &
                        ((cwr & ~w_wr_in_range) | (crd & ~w_rd_in_range));
    end

    // Memory write port; arrays are never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            case (w_bank)
                BANK_L0K0: r_mem_l0k0[L0_AW'(caddr_wr)] <= cdata_wr;
                BANK_L0K1: r_mem_l0k1[L0_AW'(caddr_wr)] <= cdata_wr;
                BANK_L1K0: r_mem_l1k0[L1_AW'(caddr_wr)] <= cdata_wr;
                BANK_L1K1: r_mem_l1k1[L1_AW'(caddr_wr)] <= cdata_wr;
                default:   r_mem_l2[L2_AW'(caddr_wr)]   <= cdata_wr;
            endcase
        end
    end

    // Read mux sees pre-edge contents, giving read-before-write on collisions.
    always_comb begin
        w_rd_word = '0;
        case (w_bank)
            BANK_L0K0: w_rd_word = r_mem_l0k0[L0_AW'(caddr_rd)];
            BANK_L0K1: w_rd_word = r_mem_l0k1[L0_AW'(caddr_rd)];
            BANK_L1K0: w_rd_word = r_mem_l1k0[L1_AW'(caddr_rd)];
            BANK_L1K1: w_rd_word = r_mem_l1k1[L1_AW'(caddr_rd)];
            default:   w_rd_word = r_mem_l2[L2_AW'(caddr_rd)];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cdata_rd <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_cdata_rd <= w_rd_word;
            end
        end
    end

    // Saturating counters; a clear wins over a same-cycle write.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            w_cnt_nxt[b] = r_cnt[b];
            if (clr_status) begin
                w_cnt_nxt[b] = '0;
            end else if (w_wr_en && (w_bank == 3'(b)) &&
                         (r_cnt[b] != CNT_W'(bank_depth(3'(b))))) begin
                w_cnt_nxt[b] = r_cnt[b] + CNT_W'(1);
            end
            w_full_nxt[b] = (w_cnt_nxt[b] == CNT_W'(bank_depth(3'(b))));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                r_cnt[b] <= '0;
            end
            r_layer_full <= '0;
            r_err_sel    <= 1'b0;
            r_err_addr   <= 1'b0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                r_cnt[b] <= w_cnt_nxt[b];
            end
            r_layer_full <= w_full_nxt;
            if (clr_status) begin
                r_err_sel  <= 1'b0;
                r_err_addr <= 1'b0;
            end else begin
                r_err_sel  <= r_err_sel | w_sel_err;
                r_err_addr <= r_err_addr | w_addr_err;
            end
        end
    end

    assign cdata_rd   = r_cdata_rd;
    assign rd_valid   = r_rd_valid;
    assign layer_full = r_layer_full;
    assign err_sel    = r_err_sel;
    assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_layer_mem_responder.sv
// Bench for layer_mem_responder: directed scenarios plus random traffic,
// every cycle compared against a behavioural bank/counter/flag model.
module tb_layer_mem_responder;

    localparam int unsigned DW = 20;
    localparam int L0 = 4096;
    localparam int L1 = 1024;
    localparam int L2 = 2048;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cwr;
    logic [11:0]   caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [11:0]   caddr_rd;
    logic [2:0]    csel;
    logic          clr_status;
    logic [DW-1:0] cdata_rd;
    logic          rd_valid;
    logic [4:0]    layer_full;
    logic          err_sel;
    logic          err_addr;

    always #5 clk = ~clk;

    layer_mem_responder #(
        .DATA_WIDTH(DW), .L0_DEPTH(L0), .L1_DEPTH(L1), .L2_DEPTH(L2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .csel(csel),
        .clr_status(clr_status), .cdata_rd(cdata_rd), .rd_valid(rd_valid),
        .layer_full(layer_full), .err_sel(err_sel), .err_addr(err_addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [int];
    int            m_cnt [5];
    logic          m_err_sel;
    logic          m_err_addr;
    logic          m_valid;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;

    function automatic int depth_of(input int b);
        return (b < 2) ? L0 : ((b < 4) ? L1 : L2);
    endfunction

    function automatic logic [4:0] m_full();
        logic [4:0] f;
        for (int b = 0; b < 5; b++) f[b] = (m_cnt[b] == depth_of(b));
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: update the model, clock, then compare all outputs.
    task automatic step(input bit rst, input bit w, input int aw, input logic [DW-1:0] dw,
                        input bit r, input int ar, input int sel, input bit clr);
        bit sel_ok, rd_ok, wr_ok;
        int b, d;
        reset_n    = !rst;
        cwr        = w;
        caddr_wr   = 12'(aw);
        cdata_wr   = dw;
        crd        = r;
        caddr_rd   = 12'(ar);
        csel       = 3'(sel);
        clr_status = clr;
        if (rst) begin
            m_valid    = 1'b0;
            m_rd       = '0;
            m_rd_known = 1'b1;
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_err_sel  = 1'b0;
            m_err_addr = 1'b0;
        end else begin
            sel_ok = (sel >= 1) && (sel <= 5);
            b      = sel - 1;
            d      = sel_ok ? depth_of(b) : 0;
            rd_ok  = r && sel_ok && (ar < d);
            wr_ok  = w && sel_ok && (aw < d);
            m_valid = rd_ok;
            if (rd_ok) begin
                if (m_mem.exists(b * 4096 + ar)) begin
                    m_rd       = m_mem[b * 4096 + ar];
                    m_rd_known = 1'b1;
                end else begin
                    m_rd_known = 1'b0;
                end
            end
            if (clr) begin
                for (int i = 0; i < 5; i++) m_cnt[i] = 0;
                m_err_sel  = 1'b0;
                m_err_addr = 1'b0;
            end else begin
                if ((w || r) && !sel_ok) m_err_sel = 1'b1;
                if (sel_ok && ((w && aw >= d) || (r && ar >= d))) m_err_addr = 1'b1;
                if (wr_ok && m_cnt[b] < d) m_cnt[b]++;
            end
            if (wr_ok) m_mem[b * 4096 + aw] = dw;
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_rd_known) chk("cdata_rd", 32'(cdata_rd), 32'(m_rd));
        chk("layer_full", 32'(layer_full), 32'(m_full()));
        chk("err_sel", 32'(err_sel), 32'(m_err_sel));
        chk("err_addr", 32'(err_addr), 32'(m_err_addr));
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] pre_word;
        int sel, aw, ar;

        // Reset state
        step(1, 0, 0, '0, 0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0, 0);
        chk("reset_cdata_rd", 32'(cdata_rd), 32'h0);
        chk("reset_layer_full", 32'(layer_full), 32'h0);

        // Basic write then read on L0k0
        step(0, 1, 'h010, 20'h0A89E, 0, 0, 1, 0);
        step(0, 0, 0, '0, 1, 'h010, 1, 0);
        chk("basic_read_data", 32'(cdata_rd), 32'h0A89E);
        chk("basic_read_valid", 32'(rd_valid), 32'h1);
        idle();
        chk("basic_pulse_one_cycle", 32'(rd_valid), 32'h0);
        chk("basic_data_held", 32'(cdata_rd), 32'h0A89E);

        // Read-before-write collision on L1k0
        step(0, 1, 5, 20'h00777, 0, 0, 3, 0);
        step(0, 1, 5, 20'h00123, 1, 5, 3, 0);
        chk("rbw_old_word", 32'(cdata_rd), 32'h00777);
        step(0, 0, 0, '0, 1, 5, 3, 0);
        chk("rbw_new_word", 32'(cdata_rd), 32'h00123);

        // Write and read to different addresses in one cycle
        step(0, 1, 9, 20'h0BEEF, 1, 5, 3, 0);
        step(0, 0, 0, '0, 1, 9, 3, 0);
        chk("dual_port_store", 32'(cdata_rd), 32'h0BEEF);

        // Out-of-range L1k1 write must not alias onto address 0
        step(0, 1, 0, 20'h0AAAA, 0, 0, 4, 0);
        step(0, 1, 1024, 20'h05555, 0, 0, 4, 0);
        chk("oor_err_addr", 32'(err_addr), 32'h1);
        step(0, 0, 0, '0, 1, 0, 4, 0);
        chk("oor_no_store", 32'(cdata_rd), 32'h0AAAA);
        step(0, 0, 0, '0, 1, 3, 6, 0);
        chk("bad_sel_err", 32'(err_sel), 32'h1);
        chk("bad_sel_no_valid", 32'(rd_valid), 32'h0);
        chk("bad_sel_data_held", 32'(cdata_rd), 32'h0AAAA);
        step(0, 0, 0, '0, 0, 0, 0, 1);
        chk("clr_err_sel", 32'(err_sel), 32'h0);
        chk("clr_err_addr", 32'(err_addr), 32'h0);

        // Fill L2 to its depth, then one more write (saturates)
        for (int i = 0; i < L2; i++) step(0, 1, i, DW'($urandom), 0, 0, 5, 0);
        chk("l2_full", 32'(layer_full), 32'h10);
        step(0, 1, 7, 20'h01234, 0, 0, 5, 0);
        chk("l2_full_saturated", 32'(layer_full), 32'h10);

        // Read accepted just before reset; write during reset is ignored
        step(0, 1, 7, 20'h0C0DE, 0, 0, 2, 0);
        pre_word = 20'h0C0DE;
        step(0, 0, 0, '0, 1, 7, 2, 0);
        step(1, 1, 7, 20'h0DEAD, 0, 0, 2, 0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_cdata_zero", 32'(cdata_rd), 32'h0);
        step(0, 0, 0, '0, 1, 7, 2, 0);
        chk("reset_write_ignored", 32'(cdata_rd), 32'(pre_word));

        // Fill L0k0 with a clear at write index 100 -> never full
        for (int i = 0; i < L0; i++) step(0, 1, i, DW'($urandom), 0, 0, 1, (i == 100));
        chk("l0k0_not_full_after_clear", 32'(layer_full[0]), 32'h0);
        chk("l0k0_count_3995", 32'(m_cnt[0]), 32'd3995);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            sel = int'($urandom_range(0, 7));
            aw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                                : int'($urandom_range(0, 31));
            ar  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                                : int'($urandom_range(0, 31));
            step(0, 1'($urandom), aw, DW'($urandom), 1'($urandom), ar, sel,
                 ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
